// File: rtl/spi_file_prefetch_if.sv
// Chunk request/return bus towards the SPI file reader and the byte stream to the consumer.
interface spi_file_prefetch_if;
  logic        file_request_valid;
  logic        file_request_ready;
  logic [31:0] file_request_offset;
  logic [7:0]  file_data;
  logic        file_data_avail;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output file_request_valid, file_request_offset, out_data, out_valid,
    input  file_request_ready, file_data, file_data_avail, out_ready
  );

  modport slave (
    input  file_request_valid, file_request_offset, out_data, out_valid,
    output file_request_ready, file_data, file_data_avail, out_ready
  );
endinterface

// File: rtl/spi_file_prefetch.sv
// Sequential chunk prefetcher: requests fixed-size chunks from the SPI file reader and
// buffers the returned bytes in a BRAM FIFO that feeds a valid/ready byte stream.
module spi_file_prefetch #(
  parameter int CHUNK_LEN = 1024,
  parameter int FIFO_AW   = 11
) (
  input  logic                clk,
  input  logic                resetq,
  input  logic                start,
  input  logic                stop,
  input  logic [31:0]         base_offset,
  input  logic [31:0]         total_len,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  spi_file_prefetch_if.master bus
);
  localparam int CW = (CHUNK_LEN > 1) ? $clog2(CHUNK_LEN) : 1;
  localparam int FW = FIFO_AW + 1;
  localparam logic [FW-1:0] DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FW-1:0] CHUNK_W = FW'(CHUNK_LEN);
  localparam logic [CW-1:0] RX_LAST = CW'(CHUNK_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_RECV, S_FINISH} state_t;

  state_t          state_q, state_d;
  logic [31:0]     req_off_q, req_off_d;
  logic [31:0]     remaining_q, remaining_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic            abort_q, abort_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            overflow_q;
  logic [FW-1:0]   free_q, free_d;
  logic [FW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            out_valid_q;
  logic [7:0]      out_data_q;
  logic [7:0]      mem [2**FIFO_AW];

  logic wr_en, rd_en, pop, drop, req_fire, flush, mem_empty, mem_full;

  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign mem_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  // Refill the output register whenever it is empty or being drained this cycle.
  assign rd_en = !mem_empty && (!out_valid_q || bus.out_ready);
  assign pop   = out_valid_q && bus.out_ready;

  assign busy                    = busy_q;
  assign done                    = done_q;
  assign overflow                = overflow_q;
  assign bus.file_request_valid  = (state_q == S_REQ);
  assign bus.file_request_offset = req_off_q;
  assign bus.out_data            = out_data_q;
  assign bus.out_valid           = out_valid_q;

  always_comb begin
    state_d     = state_q;
    req_off_d   = req_off_q;
    remaining_d = remaining_q;
    rx_cnt_d    = rx_cnt_q;
    abort_d     = abort_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    drop        = 1'b0;
    req_fire    = 1'b0;
    flush       = 1'b0;

    if (state_q != S_IDLE && stop) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          req_off_d   = base_offset;
          remaining_d = total_len;
          abort_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = (total_len == 32'd0) ? S_FINISH : S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort_q || stop || remaining_q == 32'd0) state_d = S_FINISH;
        else if (free_q >= CHUNK_W)                   state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.file_request_ready) begin
          req_fire  = 1'b1;
          req_off_d = req_off_q + 32'(CHUNK_LEN);
          rx_cnt_d  = '0;
          state_d   = S_RECV;
        end else if (stop) begin
          state_d = S_FINISH;
        end
      end
      S_RECV: begin
        // Upstream has no backpressure: the whole chunk is always absorbed.
        if (bus.file_data_avail) begin
          rx_cnt_d = rx_cnt_q + CW'(1);
          if (remaining_q != 32'd0 && !abort_q) begin
            wr_en       = !mem_full;
            remaining_d = remaining_q - 32'd1;
          end else begin
            drop = 1'b1;
          end
          if (rx_cnt_q == RX_LAST) state_d = S_CHECK;
        end
      end
      S_FINISH: begin
        if (abort_q) begin
          flush   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (mem_empty && !out_valid_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // free = unreserved FIFO slots; a kept byte was already paid for by its reservation.
    free_d = free_q;
    if (req_fire) free_d = free_d - CHUNK_W;
    if (pop)      free_d = free_d + FW'(1);
    if (drop)     free_d = free_d + FW'(1);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q     <= S_IDLE;
      req_off_q   <= '0;
      remaining_q <= '0;
      rx_cnt_q    <= '0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      free_q      <= DEPTH;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_off_q   <= req_off_d;
      remaining_q <= remaining_d;
      rx_cnt_q    <= rx_cnt_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_q | (bus.file_data_avail & mem_full);
      free_q      <= flush ? DEPTH : free_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + FW'(1);
      if (flush) begin
        rd_ptr_q    <= wr_ptr_q;
        out_valid_q <= 1'b0;
      end else if (rd_en) begin
        out_data_q  <= mem[rd_ptr_q[FIFO_AW-1:0]];
        rd_ptr_q    <= rd_ptr_q + FW'(1);
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[FIFO_AW-1:0]] <= bus.file_data;
  end
endmodule

// File: doc/spi_file_prefetch.md
Name: spi_file_prefetch

Overview:
- Sits directly downstream of the SPI file-read block. It issues sequential fixed-length chunk requests at increasing file offsets and consumes the returned byte stream.
- Returned bytes are buffered in a BRAM FIFO and presented to the consumer (e.g. image display) over a valid/ready byte stream.
- A new chunk is requested only when the FIFO has room for a whole chunk, so the upstream stream, which has no backpressure, can never overflow.

Parameters:
CHUNK_LEN, 1024, bytes returned per request; fixed by the upstream block, must be a power of 2
FIFO_AW, 11, FIFO address width; depth 2^FIFO_AW bytes, must be >= log2(CHUNK_LEN)+1

Ports:
clk  input  1  system clock
resetq  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: begin streaming; honoured only when busy=0
stop  input  1  one-cycle pulse: abort the current stream; ignored when busy=0
base_offset  input  32  file byte offset of the first byte; sampled on start
total_len  input  32  number of bytes to deliver; sampled on start; 0 allowed
busy  output  1  high from the cycle after an accepted start until the return to IDLE
done  output  1  one-cycle pulse when all total_len bytes have been consumed, or when an abort completes
overflow  output  1  sticky error: file_data_avail seen while the FIFO is full; cleared only by reset
file_request_valid  output  1  chunk request valid
file_request_ready  input  1  chunk request accepted
file_request_offset  output  32  byte offset of the requested chunk
file_data  input  8  returned byte
file_data_avail  input  1  returned byte strobe; no backpressure
out_data  output  8  byte to the consumer
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts the byte

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE.
- Registers:
  - req_off (32b): next chunk offset.
  - remaining (32b): bytes still to forward into the FIFO.
  - rx_cnt (log2(CHUNK_LEN) bits): position within the current chunk.
  - abort flag.
  - free counter: FIFO free entries minus bytes reserved for the outstanding chunk.
- IDLE:
  - On start: load req_off=base_offset, remaining=total_len, clear abort, set busy.
  - If total_len=0, go to FINISH; otherwise go to CHECK.
- CHECK:
  - If abort, or remaining=0 and no chunk outstanding: go to FINISH.
  - Else if free >= CHUNK_LEN: go to REQ.
  - Else stay in CHECK.
- REQ:
  - file_request_valid=1 and file_request_offset=req_off, both held stable until file_request_ready.
  - On the valid&ready cycle: req_off += CHUNK_LEN (32-bit wrap), free -= CHUNK_LEN, rx_cnt=0, go to RECV.
- RECV, on each file_data_avail:
  - rx_cnt++.
  - If remaining>0 and abort=0: write the byte to the FIFO and decrement remaining.
  - Otherwise drop the byte and return its reserved slot to free. This covers the tail of the final chunk beyond total_len and bytes after stop.
  - After byte CHUNK_LEN-1 (rx_cnt wraps to 0): go to CHECK.
  - Exactly CHUNK_LEN bytes are always consumed per request, even when aborted.
- FINISH:
  - Normal completion: wait until the FIFO is empty and the last byte has been consumed by out_valid&out_ready.
  - Aborted: flush the FIFO immediately and set out_valid=0.
  - Then pulse done for 1 cycle, clear busy, go to IDLE.
- stop:
  - Sets abort in any non-IDLE state.
  - In REQ with file_request_ready not yet seen: drop file_request_valid next cycle and go to FINISH without issuing the request.
  - In RECV: keep counting and discarding until the chunk ends, so upstream is never left mid-transfer.
  - FIFO contents are discarded on abort.
- FIFO:
  - Bytes come from the upstream stream and leave through out_data.
  - First-word fall-through with BRAM read; a byte written into an empty FIFO at cycle N gives out_valid=1 at cycle N+2.
  - Sustains 1 byte/cycle on both ends.
  - out_data is held stable while out_valid & !out_ready.
- free is updated on a write reservation, on a consumer pop, and on a dropped byte. Simultaneous reserve and pop in the same cycle must net correctly.
- file_data_avail outside RECV is ignored (not written), and sets overflow only if the FIFO is full.
- start while busy=1 is ignored; simultaneous start and stop in IDLE is treated as start only.
- Asynchronous reset mid-operation returns to IDLE immediately. Any upstream transfer still in flight is the upstream block's concern.

Test Plan:
- base_offset=0x1000, total_len=2048, out_ready=1, upstream model → requests at 0x1000 then 0x1400; 2048 bytes delivered in order; one done pulse; busy low after.
- total_len=1500 → 2 requests (0x0, 0x400); exactly 1500 bytes out; 548 tail bytes dropped; final free back to 2^FIFO_AW.
- out_ready=0 for 3000 cycles, total_len=4096, FIFO_AW=11 → at most 2 requests outstanding before the first pop; no overflow; third request issued only after ≥1024 bytes are popped.
- stop mid-RECV at byte 300 of chunk 1 → remaining 723 bytes are absorbed; no further request; FIFO flushed; done pulses; out_valid=0.
- total_len=0 → no request; done pulses 1–2 cycles after start. Separately: file_request_ready held low 50 cycles → offset and valid stable throughout.
- Async reset asserted in RECV with FIFO half full → all outputs 0 immediately; a subsequent start behaves as from power-up.
